// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the condition/flag unit: condition-code encodings
// and the bit positions of each flag inside a 4-bit NZCV word.
// No logic lives here; everything is constants.
package cond_flag_unit_pkg;

  // ARM condition-code encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flag bit positions within a flag word
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Purpose: evaluate one 4-bit condition code against a 4-bit flag word.
// Latency: purely combinational.
// Backpressure: none; no state.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic z, c, n, v;

  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign n = flags_i[FLAG_N];
  assign v = flags_i[FLAG_V];

  // Decode the condition field into a single should-execute bit
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Purpose: hold NZCV, evaluate LANES condition codes per cycle against the
// bypassed effective flags, and keep a bounded flag save/restore stack.
// Latency: 1 cycle cond_in -> exec_out. Backpressure: stall_in freezes all
// state; flush_in still clears valid_out/exec_out while stalled.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int SAVE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [LANES-1:0]   valid_in,
  input  logic [4*LANES-1:0] cond_in,
  input  logic               flag_we_in,
  input  logic [3:0]         flags_in,
  input  logic [3:0]         flag_mask_in,
  input  logic               save_in,
  input  logic               restore_in,
  output logic [3:0]         cpsr_out,
  output logic [LANES-1:0]   valid_out,
  output logic [LANES-1:0]   exec_out,
  output logic               stack_full_out,
  output logic               stack_empty_out,
  output logic               stack_err_out
);

  localparam int CW = $clog2(SAVE_DEPTH + 1);
  localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SAVE_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [3:0]       cpsr_q, cpsr_d;
  logic [LANES-1:0] valid_q, valid_d;
  logic [LANES-1:0] exec_q, exec_d;
  logic             err_q, err_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       stack_q [SAVE_DEPTH];

  logic             full, empty, conflict, restore_ok, push_ok;
  logic [3:0]       stack_top, flags_wr, flags_eff;
  logic [LANES-1:0] pass;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign stack_top = stack_q[IW'(count_q - ONE_C)];

  // Combined save+restore is a conflict: neither happens, the write path wins
  assign conflict   = save_in && restore_in;
  assign restore_ok = restore_in && !conflict && !empty;
  assign push_ok    = save_in && !conflict && !full;

  // Effective flags for this cycle: successful restore, else masked write
  always_comb begin
    flags_wr  = (cpsr_q & ~flag_mask_in) | (flags_in & flag_mask_in);
    flags_eff = cpsr_q;
    if (restore_ok) begin
      flags_eff = stack_top;
    end else if (flag_we_in) begin
      flags_eff = flags_wr;
    end
  end

  // One evaluator per lane, all looking at the same effective flags
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_eval u_eval (
      .cond_i  (cond_in[4*i +: 4]),
      .flags_i (flags_eff),
      .pass_o  (pass[i])
    );
  end

  // Next-state for pipeline outputs, CPSR, stack count and sticky error
  always_comb begin
    valid_d = valid_in & ~{LANES{flush_in}};
    exec_d  = pass & valid_in & ~{LANES{flush_in}};
    cpsr_d  = flags_eff;
    err_d   = err_q | conflict | (save_in && full) | (restore_in && empty);
    count_d = count_q;
    if (push_ok) begin
      count_d = count_q + ONE_C;
    end else if (restore_ok) begin
      count_d = count_q - ONE_C;
    end
  end

  // State update; a stall holds everything except a flush of the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpsr_q  <= '0;
      valid_q <= '0;
      exec_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (!stall_in) begin
      cpsr_q  <= cpsr_d;
      valid_q <= valid_d;
      exec_q  <= exec_d;
      err_q   <= err_d;
      count_q <= count_d;
      if (push_ok) begin
        stack_q[IW'(count_q)] <= cpsr_q;
      end
    end else if (flush_in) begin
      valid_q <= '0;
      exec_q  <= '0;
    end
  end

  assign cpsr_out        = cpsr_q;
  assign valid_out       = valid_q;
  assign exec_out        = exec_q;
  assign stack_full_out  = full;
  assign stack_empty_out = empty;
  assign stack_err_out   = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit (LANES=2, SAVE_DEPTH=4): directed steps plus
// randomized traffic, checked against a queue-based reference model.
module tb_cond_flag_unit;

  localparam int LANES      = 2;
  localparam int SAVE_DEPTH = 4;

  logic               clk;
  logic               reset;
  logic               stall_in;
  logic               flush_in;
  logic [LANES-1:0]   valid_in;
  logic [4*LANES-1:0] cond_in;
  logic               flag_we_in;
  logic [3:0]         flags_in;
  logic [3:0]         flag_mask_in;
  logic               save_in;
  logic               restore_in;
  logic [3:0]         cpsr_out;
  logic [LANES-1:0]   valid_out;
  logic [LANES-1:0]   exec_out;
  logic               stack_full_out;
  logic               stack_empty_out;
  logic               stack_err_out;

  cond_flag_unit #(.LANES(LANES), .SAVE_DEPTH(SAVE_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .flush_in        (flush_in),
    .valid_in        (valid_in),
    .cond_in         (cond_in),
    .flag_we_in      (flag_we_in),
    .flags_in        (flags_in),
    .flag_mask_in    (flag_mask_in),
    .save_in         (save_in),
    .restore_in      (restore_in),
    .cpsr_out        (cpsr_out),
    .valid_out       (valid_out),
    .exec_out        (exec_out),
    .stack_full_out  (stack_full_out),
    .stack_empty_out (stack_empty_out),
    .stack_err_out   (stack_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0]       m_cpsr;
  logic [3:0]       m_stack[$];
  logic             m_err;
  logic [LANES-1:0] m_valid;
  logic [LANES-1:0] m_exec;

  // Condition codes come in true/false pairs; the odd code negates the even one
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic z, c, n, v, r;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (code >> 1)
      4'd0:    r = z;
      4'd1:    r = c;
      4'd2:    r = n;
      4'd3:    r = v;
      4'd4:    r = c && !z;
      4'd5:    r = (n == v);
      4'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return r ^ code[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cpsr"},  32'(cpsr_out),        32'(m_cpsr));
    check({tag, ".valid"}, 32'(valid_out),       32'(m_valid));
    check({tag, ".exec"},  32'(exec_out),        32'(m_exec));
    check({tag, ".full"},  32'(stack_full_out),  32'(m_stack.size() == SAVE_DEPTH));
    check({tag, ".empty"}, 32'(stack_empty_out), 32'(m_stack.size() == 0));
    check({tag, ".err"},   32'(stack_err_out),   32'(m_err));
  endtask

  task automatic clear_inputs();
    stall_in = 0; flush_in = 0; valid_in = '0; cond_in = '0;
    flag_we_in = 0; flags_in = '0; flag_mask_in = '0;
    save_in = 0; restore_in = 0;
  endtask

  // Predict from current inputs, take one clock edge, then compare
  task automatic tick(input string tag);
    logic [3:0]       f;
    logic [LANES-1:0] nv, ne;
    logic             st, fl, sv, rs, conflict;
    st = stall_in; fl = flush_in; sv = save_in; rs = restore_in;
    conflict = sv && rs;
    if (rs && !conflict && m_stack.size() > 0) f = m_stack[m_stack.size()-1];
    else if (flag_we_in) f = (m_cpsr & ~flag_mask_in) | (flags_in & flag_mask_in);
    else f = m_cpsr;
    for (int i = 0; i < LANES; i++) begin
      nv[i] = valid_in[i] && !fl;
      ne[i] = valid_in[i] && !fl && ref_cond(cond_in[4*i +: 4], f);
    end
    @(posedge clk);
    #1;
    if (!st) begin
      m_valid = nv;
      m_exec  = ne;
      if (conflict) m_err = 1'b1;
      else if (sv) begin
        if (m_stack.size() == SAVE_DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_cpsr);
      end else if (rs) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else void'(m_stack.pop_back());
      end
      m_cpsr = f;
    end else if (fl) begin
      m_valid = '0;
      m_exec  = '0;
    end
    check_model(tag);
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    m_cpsr = '0; m_stack.delete(); m_err = 1'b0; m_valid = '0; m_exec = '0;
    check_model(tag);
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] hold_cpsr;
    logic [LANES-1:0] hold_valid, hold_exec;
    clear_inputs();
    reset = 1'b1;
    m_cpsr = '0; m_err = 1'b0; m_valid = '0; m_exec = '0;
    #1;
    check_model("reset");
    check("reset.cpsr_const", 32'(cpsr_out), 32'h0);
    check("reset.empty_const", 32'(stack_empty_out), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic evaluation with flags 0: EQ fails, AL passes, NV fails
    valid_in = 2'b11; cond_in = {4'hE, 4'h0};
    tick("basic0");
    check("basic0.exec_const", 32'(exec_out), 32'h2);
    cond_in = {4'h0, 4'hF};
    tick("basic1");
    check("basic1.exec_const", 32'(exec_out), 32'h0);
    check("basic1.cpsr_const", 32'(cpsr_out), 32'h0);

    // Same-cycle bypass of a masked flag write (Z and N)
    flag_we_in = 1; flags_in = 4'b1111; flag_mask_in = 4'b0101; cond_in = {4'h0, 4'h0};
    tick("bypass");
    check("bypass.exec_const", 32'(exec_out), 32'h3);
    check("bypass.cpsr_const", 32'(cpsr_out), 32'h5);

    // All 16 codes against all 16 flag values, both lanes given the same code
    flag_mask_in = 4'hF;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        flags_in = 4'(f);
        cond_in  = {4'(c), 4'(c)};
        tick("sweep");
      end
    end

    // Stack: 5 pushes of distinct values, then 5 pops
    do_reset("rst1");
    flag_we_in = 1; flag_mask_in = 4'hF; flags_in = 4'h1;
    tick("pre_push");
    save_in = 1;
    for (int k = 0; k < 5; k++) begin
      flags_in = 4'(k + 2);
      tick("push");
      check("push.full_const", 32'(stack_full_out), 32'(k >= 3));
      check("push.err_const", 32'(stack_err_out), 32'(k == 4));
    end
    save_in = 0; flag_we_in = 0; restore_in = 1;
    for (int k = 0; k < 4; k++) begin
      tick("pop");
      check("pop.cpsr_const", 32'(cpsr_out), 32'(4 - k));
    end
    tick("pop_empty");
    check("pop_empty.cpsr_const", 32'(cpsr_out), 32'h1);
    check("pop_empty.err_const", 32'(stack_err_out), 32'h1);
    restore_in = 0;

    // Stall with write and save pending: state frozen, flush clears outputs
    valid_in = 2'b11; cond_in = {4'hE, 4'hE};
    tick("pre_stall");
    hold_cpsr = cpsr_out; hold_valid = valid_out; hold_exec = exec_out;
    stall_in = 1; flag_we_in = 1; flags_in = 4'hA; save_in = 1; cond_in = {4'hF, 4'hF};
    for (int k = 0; k < 2; k++) begin
      tick("stall");
      check("stall.cpsr_hold", 32'(cpsr_out), 32'(hold_cpsr));
      check("stall.valid_hold", 32'(valid_out), 32'(hold_valid));
      check("stall.exec_hold", 32'(exec_out), 32'(hold_exec));
      check("stall.empty_hold", 32'(stack_empty_out), 32'h1);
    end
    flush_in = 1;
    tick("stall_flush");
    check("stall_flush.valid_const", 32'(valid_out), 32'h0);
    check("stall_flush.cpsr_hold", 32'(cpsr_out), 32'(hold_cpsr));
    clear_inputs();

    // Restore wins over a same-cycle flag write; save+restore is a conflict
    do_reset("rst2");
    flag_we_in = 1; flag_mask_in = 4'hF; flags_in = 4'b1010;
    tick("rw_set");
    flag_we_in = 0; save_in = 1;
    tick("rw_push");
    save_in = 0; flag_we_in = 1; flags_in = 4'b0011;
    tick("rw_other");
    restore_in = 1; flags_in = 4'b0001;
    tick("rw_restore");
    check("rw_restore.cpsr_const", 32'(cpsr_out), 32'hA);
    check("rw_restore.err_const", 32'(stack_err_out), 32'h0);
    restore_in = 0; flag_we_in = 0; save_in = 1;
    tick("sr_push");
    restore_in = 1;
    tick("save_restore");
    check("save_restore.empty_const", 32'(stack_empty_out), 32'h0);
    check("save_restore.err_const", 32'(stack_err_out), 32'h1);
    check("save_restore.cpsr_const", 32'(cpsr_out), 32'hA);
    clear_inputs();

    // Randomized traffic with an asynchronous reset partway through
    do_reset("rst3");
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset("rst_mid");
      stall_in     = ($urandom_range(0, 7) == 0);
      flush_in     = ($urandom_range(0, 7) == 0);
      valid_in     = LANES'($urandom);
      cond_in      = (4*LANES)'($urandom);
      flag_we_in   = $urandom_range(0, 1) == 1;
      flags_in     = 4'($urandom);
      flag_mask_in = 4'($urandom);
      save_in      = ($urandom_range(0, 4) == 0);
      restore_in   = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Registered condition-evaluation and flag-state unit for the CPU pipeline. It holds the architectural NZCV flags and evaluates all 16 ARM condition codes for up to LANES instructions per cycle, with one-cycle registered output. Flag writes from execute are accepted under a per-flag mask and bypassed into same-cycle evaluation. A bounded save/restore stack preserves flags across exception entry and return. It sits between decode and execute and drives each instruction's should-execute qualifier.

## Interface
- LANES, 1: instructions evaluated per cycle.
- SAVE_DEPTH, 4: flag save-stack entries, ≥1.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_in  in  1  freeze all state.
- flush_in  in  1  kill results in flight.
- valid_in  in  LANES  lane i holds an instruction.
- cond_in  in  4*LANES  condition field; lane i at [4i+3:4i].
- flag_we_in  in  1  flag write from execute.
- flags_in  in  4  new flags; bit0 Z, bit1 C, bit2 N, bit3 V.
- flag_mask_in  in  4  per-flag write enable, same bit order.
- save_in  in  1  push current flags.
- restore_in  in  1  pop flags into CPSR.
- cpsr_out  out  4  architectural flags, registered.
- valid_out  out  LANES  registered lane valid.
- exec_out  out  LANES  registered should-execute, meaningful only with valid_out.
- stack_full_out  out  1  SAVE_DEPTH entries held.
- stack_empty_out  out  1  no entries held.
- stack_err_out  out  1  sticky overflow/underflow/conflict.

## Operation
- Effective flags F (combinational, this cycle): restore_in && !empty → stack top; else flag_we_in → (cpsr & ~mask) | (flags_in & mask); else cpsr.
- Every lane evaluates cond_in against the same F. There is no intra-cycle ordering between lanes.
- Codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Clock edge, !stall_in:
  - valid_out ← valid_in & ~{LANES{flush_in}}.
  - exec_out ← eval result & valid_in & ~flush.
  - cpsr ← F.
- CPSR update priority: restore beats flag write. A flag write in the same cycle as a successful restore is discarded.
- save_in:
  - Pushes the pre-update cpsr; this cycle's flag write still lands in cpsr.
  - When full: push is dropped and stack_err set.
- restore_in when empty: cpsr follows the flag-write path, stack is unchanged, and stack_err is set.
- save_in && restore_in together: no stack change, restore ignored, stack_err set.
- stall_in: no register changes, including cpsr, stack and err. Exception: flush_in still clears valid_out and exec_out.
- stack_err clears only on reset.

## Timing
- Evaluation latency 1 cycle: cond_in at edge k gives exec_out after edge k.
- A flag write at edge k is visible to cond_in in the same cycle through the bypass, and on cpsr_out after edge k.
- Full throughput: LANES evaluations per cycle, no bubbles.
- Reset values:
  - cpsr_out, valid_out, exec_out, stack_err_out: 0.
  - stack_empty_out 1, stack_full_out 0 (0 entries).
- Reset asserted mid-operation discards in-flight results and the stack on assertion, asynchronously.
- Pointer: 0..SAVE_DEPTH with no wrap. full = (count==SAVE_DEPTH), empty = (count==0); both are registered-state derived.

## Structure
- Shared package holds:
  - The 16 condition-code constants (COND_EQ…COND_NV).
  - Flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3.
- Sub-module cond_eval: purely combinational 4-bit code + 4-bit flags → 1 bit, instantiated LANES times via generate.
- Save stack is an array of SAVE_DEPTH×4 bits plus a $clog2(SAVE_DEPTH+1) count, kept in the top level.

## Test plan
- Reset, then cond_in lanes = 0000/1110/1111, flags 0 → one cycle later exec_out = 0/1/0; cpsr_out=0, stack_empty_out=1.
- cpsr=0000, flag_we_in with flags 1111 and mask 0101 (Z,N) in the same cycle as cond EQ → exec_out=1, cpsr_out=0101.
- Sweep all 16 codes × 16 flag values against the table above, LANES=2. Lanes must agree when given identical codes.
- SAVE_DEPTH=4:
  - 5 pushes of distinct flags → full after the 4th; 5th dropped with stack_err=1.
  - 4 pops return values in LIFO order; a further pop leaves cpsr unchanged and stack_err stays 1.
- stall_in high for 3 cycles with flag_we_in and save_in → cpsr, count and outputs unchanged. flush_in during the stall → valid_out=0 next cycle.
- Restore (top=1010) together with flag_we_in flags 0001, mask 1111 → cpsr_out=1010. Simultaneous save+restore → no stack change, stack_err=1.
